aespim_ghash32: RTL and testbench
=================================

AESPIM_GHASH32 -- requirements
Module: aespim_ghash32

Interface
REQ-001 SHALL have ports: clk_i  in  1  sole clock, rising edge.
REQ-002 SHALL have ports: rst_i  in  1  reset, asynchronous, active-high.
REQ-003 SHALL have ports: key_valid_i  in  1 / key_i  in  32 / key_ready_o  out  1  hash-key load handshake.
REQ-004 SHALL have ports: msg_valid_i  in  1 / msg_data_i  in  32 / msg_last_i  in  1 / msg_ready_o  out  1  message word stream.
REQ-005 SHALL have ports: tag_valid_o  out  1 / tag_o  out  32 / tag_ready_i  in  1  result handshake.
REQ-006 SHALL have ports: abort_i  in  1  synchronous discard of the message in flight.
REQ-007 SHALL have ports: gmul_a_o  out  32 / gmul_b_o  out  32 / gmul_s_o  out  2  operands to the external GF(2^32) multiplier.
REQ-008 SHALL have ports: gmul_c0_i  in  32  fully reduced product (mod x^32+x^17+x^15+x^14+1), combinational from gmul_a_o/gmul_b_o.
REQ-009 SHALL have ports: busy_o  out  1  high in MUL or OUT.
REQ-010 SHALL have no parameters. Widths are fixed.

Function
REQ-011 SHALL compute the Horner hash tag = (...((m0^0)·H ^ m1)·H ...)·H over one message, where H is the loaded key, ^ is XOR, and · is the GF(2^32) product.
REQ-012 SHALL implement FSM states IDLE (no key), READY, MUL and OUT. Registers: h, acc, x and last_q.
REQ-013 IDLE: key_ready_o=1 and msg_ready_o=0. On a key handshake, h<=key_i, acc<=0 and the FSM goes to READY.
REQ-014 READY: key_ready_o=1 and msg_ready_o=!key_valid_i. Key load has priority over a message word in the same cycle; the key load sets h<=key_i and acc<=0, and the FSM stays in READY.
REQ-015 READY message handshake: x<=acc^msg_data_i and last_q<=msg_last_i, then the FSM goes to MUL.
REQ-016 MUL (exactly 1 cycle): gmul_a_o=x, gmul_b_o=h, gmul_s_o=2'b00. At the clock edge, acc<=gmul_c0_i; the FSM goes to OUT if last_q, else to READY.
REQ-017 Outside MUL: gmul_a_o=0, gmul_b_o=0, gmul_s_o=2'b00.
REQ-018 OUT: tag_valid_o=1 and tag_o=acc, both stable until tag_ready_i. On the tag handshake, acc<=0 and the FSM goes to READY (key retained).
REQ-019 tag_o SHALL read 0 whenever tag_valid_o=0.
REQ-020 Throughput: one word per 2 cycles. Latency: the tag is valid 2 cycles after the last-word handshake.
REQ-021 key_ready_o and msg_ready_o SHALL be 0 in MUL and OUT. Key changes take effect only between messages.
REQ-022 abort_i (highest priority after reset): acc<=0, no tag is emitted, and the FSM goes to READY (or stays in IDLE if no key has been loaded). Any handshake occurring in the same cycle is ignored.
REQ-023 A message of a single word with last=1 is legal. Zero-length messages are not supported.
REQ-024 acc and x SHALL remain 32 bits wide; no width growth is permitted.

Reset
REQ-025 While rst_i=1, asynchronously: state=IDLE; h, acc, x, last_q=0; all outputs 0.
REQ-026 Reset asserted mid-MUL or mid-OUT SHALL discard all work, including the key. The first cycle after release is IDLE.

Verification
REQ-027 Load key 0x00000001, send words 0x12345678 then 0x0F0F0F0F (last) -> tag_o=0x1D3B5977, tag_valid_o high 2 cycles after the last handshake.
REQ-028 Load key 0x00000002, send single word 0x80000000 (last) -> tag_o=0x0002C001. Load key 0x00000002, send single word 0x00000001 (last) -> tag_o=0x00000002.
REQ-029 Load key 0x00000000, send any 3 words -> tag_o=0x00000000. Hold tag_ready_i=0 for 5 cycles -> tag_valid_o and tag_o stay stable, msg_ready_o=0.
REQ-030 In READY, assert key_valid_i and msg_valid_i together -> msg_ready_o=0, the key is loaded, acc=0, and the word is accepted on the following cycle.
REQ-031 Pulse abort_i in MUL, then send 0xA5A5A5A5 (last) with key 0x00000001 -> tag_o=0xA5A5A5A5. Assert rst_i in OUT -> all outputs 0 immediately, and the FSM is in IDLE after release.

Source files
------------

// File: rtl/aespim_ghash32.sv
// Horner GHASH over 32-bit words using an external GF(2^32) multiplier; one word per 2 cycles,
// tag valid 2 cycles after the last word; ready drops in MUL/OUT and the tag holds until tag_ready_i.
module aespim_ghash32 (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        key_valid_i,
  input  logic [31:0] key_i,
  output logic        key_ready_o,
  input  logic        msg_valid_i,
  input  logic [31:0] msg_data_i,
  input  logic        msg_last_i,
  output logic        msg_ready_o,
  output logic        tag_valid_o,
  output logic [31:0] tag_o,
  input  logic        tag_ready_i,
  input  logic        abort_i,
  output logic [31:0] gmul_a_o,
  output logic [31:0] gmul_b_o,
  output logic [1:0]  gmul_s_o,
  input  logic [31:0] gmul_c0_i,
  output logic        busy_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READY = 2'd1,
    ST_MUL   = 2'd2,
    ST_OUT   = 2'd3
  } state_t;

  state_t      state;
  logic [31:0] h;
  logic [31:0] acc;
  logic [31:0] x;
  logic        last_q;

  logic st_idle, st_ready, st_mul, st_out;

  assign st_idle  = (state == ST_IDLE);
  assign st_ready = (state == ST_READY);
  assign st_mul   = (state == ST_MUL);
  assign st_out   = (state == ST_OUT);

  // IDLE is the reset state but still advertises key_ready, so gate it with rst_i
  // to keep every output at 0 while reset is held.
  assign key_ready_o = !rst_i && (st_idle || st_ready);
  assign msg_ready_o = st_ready && !key_valid_i;
  assign tag_valid_o = st_out;
  assign tag_o       = st_out ? acc : 32'd0;
  assign busy_o      = st_mul || st_out;

  assign gmul_a_o = st_mul ? x : 32'd0;
  assign gmul_b_o = st_mul ? h : 32'd0;
  assign gmul_s_o = 2'b00;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state  <= ST_IDLE;
      h      <= 32'd0;
      acc    <= 32'd0;
      x      <= 32'd0;
      last_q <= 1'b0;
    end else if (abort_i) begin
      // Abort discards the message but keeps the key; IDLE means no key yet.
      acc   <= 32'd0;
      state <= st_idle ? ST_IDLE : ST_READY;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (key_valid_i) begin
            h     <= key_i;
            acc   <= 32'd0;
            state <= ST_READY;
          end
        end
        ST_READY: begin
          if (key_valid_i) begin
            h   <= key_i;
            acc <= 32'd0;
          end else if (msg_valid_i) begin
            x      <= acc ^ msg_data_i;
            last_q <= msg_last_i;
            state  <= ST_MUL;
          end
        end
        ST_MUL: begin
          acc   <= gmul_c0_i;
          state <= last_q ? ST_OUT : ST_READY;
        end
        ST_OUT: begin
          if (tag_ready_i) begin
            acc   <= 32'd0;
            state <= ST_READY;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aespim_ghash32.sv
// Directed and randomized checks of aespim_ghash32 against a Horner-hash reference model.
module tb_aespim_ghash32;

  typedef logic [31:0] wq_t[$];

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        key_valid_i;
  logic [31:0] key_i;
  logic        key_ready_o;
  logic        msg_valid_i;
  logic [31:0] msg_data_i;
  logic        msg_last_i;
  logic        msg_ready_o;
  logic        tag_valid_o;
  logic [31:0] tag_o;
  logic        tag_ready_i;
  logic        abort_i;
  logic [31:0] gmul_a_o;
  logic [31:0] gmul_b_o;
  logic [1:0]  gmul_s_o;
  logic [31:0] gmul_c0_i;
  logic        busy_o;

  int checks   = 0;
  int failures = 0;

  aespim_ghash32 dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .key_valid_i(key_valid_i), .key_i(key_i), .key_ready_o(key_ready_o),
    .msg_valid_i(msg_valid_i), .msg_data_i(msg_data_i), .msg_last_i(msg_last_i),
    .msg_ready_o(msg_ready_o),
    .tag_valid_o(tag_valid_o), .tag_o(tag_o), .tag_ready_i(tag_ready_i),
    .abort_i(abort_i),
    .gmul_a_o(gmul_a_o), .gmul_b_o(gmul_b_o), .gmul_s_o(gmul_s_o),
    .gmul_c0_i(gmul_c0_i), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  // Carry-less product reduced mod x^32+x^17+x^15+x^14+1.
  function automatic logic [31:0] gf_mul(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    logic [63:0] poly;
    p    = 64'd0;
    poly = (64'd1 << 32) | (64'd1 << 17) | (64'd1 << 15) | (64'd1 << 14) | 64'd1;
    for (int i = 0; i < 32; i++)
      if (b[i]) p = p ^ ({32'd0, a} << i);
    for (int i = 62; i >= 32; i--)
      if (p[i]) p = p ^ (poly << (i - 32));
    return p[31:0];
  endfunction

  function automatic logic [31:0] horner(input logic [31:0] key, input wq_t w);
    logic [31:0] r;
    r = 32'd0;
    foreach (w[i]) r = gf_mul(r ^ w[i], key);
    return r;
  endfunction

  always_comb gmul_c0_i = gf_mul(gmul_a_o, gmul_b_o);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_key_ready"}, {31'd0, key_ready_o}, 32'd0);
    chk({tag, "_msg_ready"}, {31'd0, msg_ready_o}, 32'd0);
    chk({tag, "_tag_valid"}, {31'd0, tag_valid_o}, 32'd0);
    chk({tag, "_tag"}, tag_o, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy_o}, 32'd0);
    chk({tag, "_gmul_a"}, gmul_a_o, 32'd0);
    chk({tag, "_gmul_b"}, gmul_b_o, 32'd0);
    chk({tag, "_gmul_s"}, {30'd0, gmul_s_o}, 32'd0);
  endtask

  task automatic load_key(input logic [31:0] k);
    key_valid_i = 1'b1;
    key_i       = k;
    #1;
    chk("key_ready", {31'd0, key_ready_o}, 32'd1);
    tick();
    key_valid_i = 1'b0;
  endtask

  // Offers one word, waits (bounded) for the handshake, then checks the MUL cycle.
  task automatic send_word(input logic [31:0] d, input bit last, input logic [31:0] exp_a,
                           input logic [31:0] exp_b, output int waits);
    msg_valid_i = 1'b1;
    msg_data_i  = d;
    msg_last_i  = last;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (msg_ready_o) begin
        tick();
        waits       = i;
        msg_valid_i = 1'b0;
        msg_last_i  = 1'b0;
        chk("mul_busy", {31'd0, busy_o}, 32'd1);
        chk("mul_a", gmul_a_o, exp_a);
        chk("mul_b", gmul_b_o, exp_b);
        chk("mul_s", {30'd0, gmul_s_o}, 32'd0);
        chk("mul_tag_valid", {31'd0, tag_valid_o}, 32'd0);
        chk("mul_msg_ready", {31'd0, msg_ready_o}, 32'd0);
        return;
      end
      tick();
    end
    waits       = -1;
    msg_valid_i = 1'b0;
    chk("msg_handshake_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_msg(input logic [31:0] key, input wq_t w, input int hold,
                         input logic [31:0] exp_tag);
    logic [31:0] r;
    int waits;
    r = 32'd0;
    foreach (w[i]) begin
      send_word(w[i], i == w.size() - 1, r ^ w[i], key, waits);
      if (i > 0) chk("throughput_wait", waits, 32'd1);
      r = gf_mul(r ^ w[i], key);
    end
    tick();
    chk("latency_tag_valid", {31'd0, tag_valid_o}, 32'd1);
    chk("tag", tag_o, exp_tag);
    for (int c = 0; c < hold; c++) begin
      tick();
      chk("hold_tag_valid", {31'd0, tag_valid_o}, 32'd1);
      chk("hold_tag", tag_o, exp_tag);
      chk("hold_msg_ready", {31'd0, msg_ready_o}, 32'd0);
      chk("hold_key_ready", {31'd0, key_ready_o}, 32'd0);
    end
    tag_ready_i = 1'b1;
    tick();
    tag_ready_i = 1'b0;
    chk("post_tag_valid", {31'd0, tag_valid_o}, 32'd0);
    chk("post_tag_zero", tag_o, 32'd0);
    chk("post_msg_ready", {31'd0, msg_ready_o}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    wq_t w;
    int  waits;
    logic [31:0] k;

    rst_i = 1'b1; key_valid_i = 1'b0; key_i = 32'd0; msg_valid_i = 1'b0;
    msg_data_i = 32'd0; msg_last_i = 1'b0; tag_ready_i = 1'b0; abort_i = 1'b0;
    #2;
    chk_all_zero("reset");
    tick(); tick();
    rst_i = 1'b0;
    #1;
    chk("idle_key_ready", {31'd0, key_ready_o}, 32'd1);
    chk("idle_msg_ready", {31'd0, msg_ready_o}, 32'd0);

    // Abort in IDLE must not invent a key.
    abort_i = 1'b1; key_valid_i = 1'b1; key_i = 32'h1234;
    tick();
    abort_i = 1'b0; key_valid_i = 1'b0;
    #1;
    chk("abort_idle_msg_ready", {31'd0, msg_ready_o}, 32'd0);

    // Known vectors.
    load_key(32'h0000_0001);
    w = '{32'h1234_5678, 32'h0F0F_0F0F};
    run_msg(32'h1, w, 0, 32'h1D3B_5977);
    load_key(32'h0000_0002);
    w = '{32'h8000_0000};
    run_msg(32'h2, w, 0, 32'h0002_C001);
    load_key(32'h0000_0002);
    w = '{32'h0000_0001};
    run_msg(32'h2, w, 0, 32'h0000_0002);

    // Zero key with back-pressure on the tag.
    load_key(32'h0);
    w = '{$urandom, $urandom, $urandom};
    run_msg(32'h0, w, 5, 32'h0);

    // Key and word offered together: key wins, acc clears, word follows.
    load_key(32'hDEAD_BEEF);
    send_word(32'h0BAD_F00D, 1'b0, 32'h0BAD_F00D, 32'hDEAD_BEEF, waits);
    tick();
    key_valid_i = 1'b1; key_i = 32'h0000_0003;
    msg_valid_i = 1'b1; msg_data_i = 32'h0000_4321; msg_last_i = 1'b1;
    #1;
    chk("both_msg_ready", {31'd0, msg_ready_o}, 32'd0);
    chk("both_key_ready", {31'd0, key_ready_o}, 32'd1);
    tick();
    key_valid_i = 1'b0;
    #1;
    chk("both_next_msg_ready", {31'd0, msg_ready_o}, 32'd1);
    tick();
    msg_valid_i = 1'b0; msg_last_i = 1'b0;
    chk("both_gmul_a", gmul_a_o, 32'h0000_4321);
    chk("both_gmul_b", gmul_b_o, 32'h0000_0003);
    tick();
    chk("both_tag", tag_o, gf_mul(32'h0000_4321, 32'h3));
    tag_ready_i = 1'b1;
    tick();
    tag_ready_i = 1'b0;

    // Abort during MUL: no tag, back to READY with key kept.
    load_key(32'h0000_0001);
    send_word(32'h1111_1111, 1'b1, 32'h1111_1111, 32'h1, waits);
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    chk("abort_tag_valid", {31'd0, tag_valid_o}, 32'd0);
    chk("abort_busy", {31'd0, busy_o}, 32'd0);
    chk("abort_msg_ready", {31'd0, msg_ready_o}, 32'd1);
    tick();
    chk("abort_tag_valid2", {31'd0, tag_valid_o}, 32'd0);
    w = '{32'hA5A5_A5A5};
    run_msg(32'h1, w, 0, 32'hA5A5_A5A5);

    // Reset while in OUT discards everything including the key.
    send_word(32'h0000_0005, 1'b1, 32'h5, 32'h1, waits);
    tick();
    chk("pre_rst_tag_valid", {31'd0, tag_valid_o}, 32'd1);
    rst_i = 1'b1;
    #1;
    chk_all_zero("rst_in_out");
    tick();
    rst_i = 1'b0;
    msg_valid_i = 1'b1; msg_data_i = 32'h7; msg_last_i = 1'b1;
    #1;
    chk("post_rst_key_ready", {31'd0, key_ready_o}, 32'd1);
    chk("post_rst_msg_ready", {31'd0, msg_ready_o}, 32'd0);
    tick();
    chk("post_rst_busy", {31'd0, busy_o}, 32'd0);
    msg_valid_i = 1'b0; msg_last_i = 1'b0;

    // Randomized messages, re-keying each time.
    for (int m = 0; m < 12; m++) begin
      k = $urandom;
      load_key(k);
      w = {};
      for (int j = 0; j < int'($urandom_range(1, 6)); j++) w.push_back($urandom);
      run_msg(k, w, int'($urandom_range(0, 3)), horner(k, w));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
